pc_seq_ctrl: RTL and testbench

//  Multicycle PC sequencer: decides when the PC register loads and what value it loads.

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/pc_seq_ctrl_if.sv | 29 ++
 rtl/pc_seq_ctrl_watchdog.sv | 38 +++
 rtl/pc_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the multicycle PC sequencer: state encoding, default vectors, PC step.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0001_0000;
  localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0080;
  localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Bundle of fetch handshake, datapath status and PC register signals around pc_seq_ctrl.
interface pc_seq_ctrl_if;

  logic [31:0] pc_q;
  logic        iad_req;
  logic        iad_ack;
  logic        instr_valid;
  logic        done;
  logic        load_wait;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_d;
  logic        pc_en;
  logic [31:0] instr_count;
  logic        fetch_err;
  logic        trap;

  // master is the sequencer; slave is the surrounding datapath, imem and PC register
  modport master (
    input  pc_q, iad_ack, done, load_wait, redirect_valid, redirect_target,
    output iad_req, instr_valid, pc_d, pc_en, instr_count, fetch_err, trap
  );

  modport slave (
    output pc_q, iad_ack, done, load_wait, redirect_valid, redirect_target,
    input  iad_req, instr_valid, pc_d, pc_en, instr_count, fetch_err, trap
  );

endinterface

// File: rtl/pc_seq_ctrl_watchdog.sv
// fetch_watchdog: counts unacknowledged fetch cycles and raises a sticky error at FETCH_TIMEOUT.
module fetch_watchdog #(
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic fetch_err
);

  localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_inc;
  logic          hit;

  assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);
  assign hit     = cnt_inc >= (CW+1)'(FETCH_TIMEOUT);

  // Counter saturates just below the limit so it can never wrap back under it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (clear) begin
        cnt <= '0;
      end else if (enable && !hit) begin
        cnt <= cnt_inc[CW-1:0];
      end
      if (enable && hit) begin
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multicycle PC sequencer: BOOT -> FETCH -> EXEC -> UPDATE; drives PC enable/next value.
// Optional macro PC_ALIGN_TRAP_EN: misaligned redirect targets vector to TRAP_PC with a trap pulse.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEF_RESET_PC,
  parameter logic [31:0] TRAP_PC       = DEF_TRAP_PC,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  pc_seq_ctrl_if.master      bus
);

  state_t      state;
  state_t      state_nxt;
  logic        done_seen;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] tgt;
  logic        instr_valid;
  logic [31:0] instr_count;
  logic        wd_clear;
  logic        wd_en;

  assign tgt             = pend_valid ? pend_target : bus.pc_q + PC_STEP;
  assign bus.instr_valid = instr_valid;
  assign bus.instr_count = instr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_seen   <= 1'b0;
      pend_valid  <= 1'b0;
      instr_valid <= 1'b0;
      instr_count <= 32'd0;
    end else begin
      instr_valid <= (state == ST_FETCH) && bus.iad_ack;
      case (state)
        ST_EXEC: begin
          if (bus.redirect_valid) pend_valid <= 1'b1;
          if (bus.done)           done_seen  <= 1'b1;
        end
        ST_UPDATE: begin
          pend_valid  <= 1'b0;
          done_seen   <= 1'b0;
          instr_count <= instr_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Redirect target is pure data; only pend_valid qualifies it.
  always_ff @(posedge clk) begin
    if (state == ST_EXEC && bus.redirect_valid) begin
      pend_target <= bus.redirect_target;
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.iad_req = 1'b0;
    bus.pc_en   = 1'b0;
    bus.pc_d    = bus.pc_q;
    bus.trap    = 1'b0;
    case (state)
      ST_BOOT: begin
        bus.pc_d  = RESET_PC;
        bus.pc_en = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        bus.iad_req = 1'b1;
        if (bus.iad_ack) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if ((done_seen || bus.done) && !bus.load_wait) state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        bus.pc_en = 1'b1;
        state_nxt = ST_FETCH;
`ifdef PC_ALIGN_TRAP_EN
        // Only redirect targets can be misaligned; the sequential step is trusted.
        if (pend_valid && pend_target[1:0] != 2'b00) begin
          bus.pc_d = TRAP_PC;
          bus.trap = 1'b1;
        end else begin
          bus.pc_d = tgt;
        end
`else
        bus.pc_d = {tgt[31:2], 2'b00};
`endif
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

`ifndef PC_ALIGN_TRAP_EN
  logic unused_bits;
  assign unused_bits = ^{TRAP_PC, tgt[1:0]};
`endif

  assign wd_en    = (state == ST_FETCH) && !bus.iad_ack;
  assign wd_clear = (state == ST_FETCH) &&  bus.iad_ack;

  fetch_watchdog #(
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (wd_clear),
    .enable    (wd_en),
    .fetch_err (bus.fetch_err)
  );

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: instruction-level stimulus plans with a per-cycle expectation model.
module tb_pc_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h0001_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0080;
  localparam int          T      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_seq_ctrl_if bus();

  pc_seq_ctrl #(
    .RESET_PC      (RST_PC),
    .TRAP_PC       (TRP_PC),
    .FETCH_TIMEOUT (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The PC register itself lives in the environment.
  always_ff @(posedge clk) begin
    if (bus.pc_en) bus.pc_q <= bus.pc_d;
  end

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  logic        exp_req, exp_iv, exp_en, exp_trap, exp_err;
  logic [31:0] exp_pcd, exp_cnt;

  logic [31:0] m_pc  = RST_PC;
  logic [31:0] m_cnt = 32'd0;
  logic        m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        check("iad_req",     32'(bus.iad_req),     32'(exp_req));
        check("instr_valid", 32'(bus.instr_valid), 32'(exp_iv));
        check("pc_en",       32'(bus.pc_en),       32'(exp_en));
        check("pc_d",        bus.pc_d,             exp_pcd);
        check("trap",        32'(bus.trap),        32'(exp_trap));
        check("fetch_err",   32'(bus.fetch_err),   32'(exp_err));
        check("instr_count", bus.instr_count,      exp_cnt);
      end
    end
  end

  task automatic drive(input logic ack, input logic dn, input logic lw,
                       input logic rv, input logic [31:0] rt);
    @(negedge clk);
    bus.iad_ack         = ack;
    bus.done            = dn;
    bus.load_wait       = lw;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
  endtask

  task automatic set_exp(input logic req, input logic iv, input logic en,
                         input logic [31:0] pcd, input logic trp, input logic err);
    exp_req  = req;
    exp_iv   = iv;
    exp_en   = en;
    exp_pcd  = pcd;
    exp_trap = trp;
    exp_err  = err;
    exp_cnt  = m_cnt;
    chk_en   = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 1'b0;
    rst    = 1'b1;
    bus.iad_ack = 1'b0; bus.done = 1'b0; bus.load_wait = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_target = 32'd0;
    repeat (2) @(posedge clk);
    m_cnt = 32'd0;
    m_err = 1'b0;
  endtask

  task automatic boot_step();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    rst = 1'b0;
    set_exp(1'b0, 1'b0, 1'b1, RST_PC, 1'b0, m_err);
    m_pc = RST_PC;
  endtask

  // fw unacknowledged cycles, then ack; the limit is visible once T idle cycles have elapsed.
  task automatic fetch(input int fw);
    for (int i = 0; i <= fw; i++) begin
      drive(i == fw, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      set_exp(1'b1, 1'b0, 1'b0, m_pc, 1'b0, m_err || (i >= T));
    end
    if (fw >= T) m_err = 1'b1;
  endtask

  task automatic exec(input int d, input int lw, input bit rnd_redir,
                      input int rj, input logic [31:0] rtgt,
                      output logic pv, output logic [31:0] pt);
    logic        rv, lwv;
    logic [31:0] rt;
    pv = 1'b0;
    pt = 32'd0;
    for (int j = 0; j <= d + lw; j++) begin
      rv = rnd_redir && ($urandom_range(0, 2) == 0);
      rt = $urandom;
      if (j == rj) begin
        rv = 1'b1;
        rt = rtgt;
      end
      if (j < d)            lwv = 1'($urandom);
      else if (j < d + lw)  lwv = 1'b1;
      else                  lwv = 1'b0;
      drive(1'($urandom), j == d, lwv, rv, rt);
      set_exp(1'b0, j == 0, 1'b0, m_pc, 1'b0, m_err);
      if (rv) begin
        pv = 1'b1;
        pt = rt;
      end
    end
  endtask

  task automatic update(input logic pv, input logic [31:0] pt);
    logic [31:0] nxt, epc;
    logic        etrap;
    nxt   = pv ? pt : m_pc + 32'd4;
    etrap = 1'b0;
`ifdef PC_ALIGN_TRAP_EN
    if (pv && pt[1:0] != 2'b00) begin
      epc   = TRP_PC;
      etrap = 1'b1;
    end else begin
      epc = nxt;
    end
`else
    epc = nxt & 32'hFFFF_FFFC;
`endif
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    set_exp(1'b0, 1'b0, 1'b1, epc, etrap, m_err);
    m_pc  = epc;
    m_cnt = m_cnt + 32'd1;
  endtask

  task automatic instr(input int fw, input int d, input int lw, input bit rnd_redir,
                       input int rj, input logic [31:0] rtgt);
    logic        pv;
    logic [31:0] pt;
    fetch(fw);
    exec(d, lw, rnd_redir, rj, rtgt, pv, pt);
    update(pv, pt);
  endtask

  task automatic pin_pc(input string name, input logic [31:0] req);
    @(posedge clk);
    #1;
    check(name, bus.pc_q, req);
  endtask

  initial begin
    bus.iad_ack = 1'b0; bus.done = 1'b0; bus.load_wait = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_target = 32'd0;

    // 1: boot, ack two cycles into fetch, sequential update
    do_reset();
    boot_step();
    instr(2, 0, 0, 1'b0, -1, 32'd0);
    pin_pc("t1_pc_seq", 32'h0001_0004);
    check("t1_model_pc", m_pc, 32'h0001_0004);

    // 2: redirect on 2nd exec cycle, done on 4th; then plain sequential
    instr(0, 3, 0, 1'b0, 1, 32'h0001_0100);
    pin_pc("t2_pc_redir", 32'h0001_0100);
    instr(1, 0, 0, 1'b0, -1, 32'd0);
    pin_pc("t2_pc_seq", 32'h0001_0104);

    // 3: done under a five-cycle load_wait
    instr(0, 1, 5, 1'b0, -1, 32'd0);
    pin_pc("t3_pc", 32'h0001_0108);

    // 5: misaligned redirect target
    instr(0, 0, 0, 1'b0, 0, 32'h0001_0102);
`ifdef PC_ALIGN_TRAP_EN
    pin_pc("t5_pc", TRP_PC);
`else
    pin_pc("t5_pc", 32'h0001_0100);
`endif

    // randomized instruction stream
    for (int k = 0; k < 150; k++) begin
      instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 3)), 1'b1, -1, 32'd0);
    end

    // 4: fetch timeout is sticky across a later ack and cleared only by reset
    do_reset();
    boot_step();
    instr(10, 0, 0, 1'b0, -1, 32'd0);
    check("t4_err_set", 32'(bus.fetch_err), 32'd1);
    instr(0, 0, 0, 1'b0, -1, 32'd0);
    check("t4_err_sticky", 32'(bus.fetch_err), 32'd1);
    do_reset();
    boot_step();
    @(posedge clk);
    #1;
    check("t4_err_cleared", 32'(bus.fetch_err), 32'd0);

    // 6: reset in EXEC with a pending redirect, near the top of the address space
    instr(0, 0, 0, 1'b0, 0, 32'hFFFF_FFFC);
    pin_pc("t6_pc_top", 32'hFFFF_FFFC);
    fetch(0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5670);
    set_exp(1'b0, 1'b1, 1'b0, m_pc, 1'b0, m_err);
    do_reset();
    boot_step();
    check("t6_count_zero", bus.instr_count, 32'd0);
    instr(0, 0, 0, 1'b0, 0, 32'hFFFF_FFFC);
    instr(0, 0, 0, 1'b0, -1, 32'd0);
    pin_pc("t6_wrap", 32'h0000_0000);
    check("t6_count", bus.instr_count, 32'd2);

    @(negedge clk);
    chk_en = 1'b0;
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
